// File: rtl/condition_handler_unit_pkg.sv
// Shared definitions for the integer branch/condition handling slice.
package condition_handler_unit_pkg;

  // SPARC Bicc condition field encodings (instr[28:25])
  localparam logic [3:0] BN   = 4'b0000;
  localparam logic [3:0] BE   = 4'b0001;
  localparam logic [3:0] BLE  = 4'b0010;
  localparam logic [3:0] BL   = 4'b0011;
  localparam logic [3:0] BLEU = 4'b0100;
  localparam logic [3:0] BCS  = 4'b0101;
  localparam logic [3:0] BNEG = 4'b0110;
  localparam logic [3:0] BVS  = 4'b0111;
  localparam logic [3:0] BA   = 4'b1000;
  localparam logic [3:0] BNE  = 4'b1001;
  localparam logic [3:0] BG   = 4'b1010;
  localparam logic [3:0] BGE  = 4'b1011;
  localparam logic [3:0] BGU  = 4'b1100;
  localparam logic [3:0] BCC  = 4'b1101;
  localparam logic [3:0] BPOS = 4'b1110;
  localparam logic [3:0] BVC  = 4'b1111;

  // nPC source select encodings
  localparam logic [1:0] PCSEL_SEQ  = 2'b00;
  localparam logic [1:0] PCSEL_REL  = 2'b01;
  localparam logic [1:0] PCSEL_JMPL = 2'b10;

  // Bit positions inside {N,Z,V,C}
  localparam int unsigned N = 3;
  localparam int unsigned Z = 2;
  localparam int unsigned V = 1;
  localparam int unsigned C = 0;

  // Delay-slot squash tracking
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_ANNUL = 1'b1
  } annul_state_e;

endpackage

// File: rtl/condition_handler_unit_if.sv
// Decode/EX-side inputs and front-end outputs of the condition handler.
interface condition_handler_unit_if;
  logic       LE;
  logic       EX_modifyCC;
  logic [3:0] EX_flags;
  logic       EX_jmpl_instr;
  logic       ID_B_instr;
  logic       ID_29_a;
  logic [3:0] ID_cond;
  logic       ID_Call_instr;
  logic [3:0] icc;
  logic [1:0] pc_sel;
  logic       branch_taken;
  logic       S;

  modport master (
    output LE, EX_modifyCC, EX_flags, EX_jmpl_instr,
           ID_B_instr, ID_29_a, ID_cond, ID_Call_instr,
    input  icc, pc_sel, branch_taken, S
  );

  modport slave (
    input  LE, EX_modifyCC, EX_flags, EX_jmpl_instr,
           ID_B_instr, ID_29_a, ID_cond, ID_Call_instr,
    output icc, pc_sel, branch_taken, S
  );
endinterface

// File: rtl/condition_handler_unit_cond_evaluator.sv
// Combinational Bicc condition evaluation against {N,Z,V,C}.
module cond_evaluator
  import condition_handler_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  // Decode the condition field into a single truth bit
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      BN:   cond_true = 1'b0;
      BE:   cond_true = flags[Z];
      BLE:  cond_true = flags[Z] | (flags[N] ^ flags[V]);
      BL:   cond_true = flags[N] ^ flags[V];
      BLEU: cond_true = flags[C] | flags[Z];
      BCS:  cond_true = flags[C];
      BNEG: cond_true = flags[N];
      BVS:  cond_true = flags[V];
      BA:   cond_true = 1'b1;
      BNE:  cond_true = ~flags[Z];
      BG:   cond_true = ~(flags[Z] | (flags[N] ^ flags[V]));
      BGE:  cond_true = ~(flags[N] ^ flags[V]);
      BGU:  cond_true = ~(flags[C] | flags[Z]);
      BCC:  cond_true = ~flags[C];
      BPOS: cond_true = ~flags[N];
      BVC:  cond_true = ~flags[V];
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/condition_handler_unit.sv
// icc register, branch resolution, nPC select and delay-slot annul control.
module condition_handler_unit
  import condition_handler_unit_pkg::*;
#(
  parameter bit ICC_BYPASS = 1'b1
) (
  input logic                    Clk,
  input logic                    R,
  condition_handler_unit_if.slave bus
);

  logic [3:0]   icc_q, icc_d;
  annul_state_e state_q, state_d;
  logic [3:0]   flags_eff;
  logic         cond_true;
  logic         squash;
  logic         taken;
  logic         annul_next;
  logic [1:0]   pc_sel_c;

  cond_evaluator u_cond_eval (
    .cond      (bus.ID_cond),
    .flags     (flags_eff),
    .cond_true (cond_true)
  );

  // Branch resolution, nPC select and annul decision for the instruction in ID
  always_comb begin
    flags_eff = icc_q;
    if (ICC_BYPASS && bus.EX_modifyCC) flags_eff = bus.EX_flags;
    squash = (state_q == ST_ANNUL);
    // A squashed delay-slot instruction can neither branch nor annul
    taken      = ~squash & ((bus.ID_B_instr & cond_true) | bus.ID_Call_instr);
    annul_next = ~squash & ~bus.EX_jmpl_instr & bus.ID_B_instr & bus.ID_29_a &
                 (~cond_true | (bus.ID_cond == BA));
    pc_sel_c = PCSEL_SEQ;
    if (bus.EX_jmpl_instr) pc_sel_c = PCSEL_JMPL;
    else if (taken)        pc_sel_c = PCSEL_REL;
  end

  // Next-state for icc and the annul tracker; everything holds on stall
  always_comb begin
    icc_d   = icc_q;
    state_d = state_q;
    if (bus.LE) begin
      if (bus.EX_modifyCC) icc_d = bus.EX_flags;
      state_d = annul_next ? ST_ANNUL : ST_RUN;
    end
  end

  // State registers
  always_ff @(posedge Clk or posedge R) begin
    if (R) begin
      icc_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      icc_q   <= icc_d;
      state_q <= state_d;
    end
  end

  assign bus.icc          = icc_q;
  assign bus.S            = squash;
  assign bus.branch_taken = taken & ~R;
  assign bus.pc_sel       = R ? PCSEL_SEQ : pc_sel_c;

endmodule

// File: tb/tb_condition_handler_unit.sv
// Directed plus randomized checks of condition_handler_unit against a reference model.
module tb_condition_handler_unit;

  logic Clk = 1'b0;
  logic R   = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  // model state
  logic [3:0] m_icc = 4'b0000;
  logic       m_s   = 1'b0;

  condition_handler_unit_if bus ();

  condition_handler_unit #(.ICC_BYPASS(1'b1)) dut (
    .Clk (Clk),
    .R   (R),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Bicc semantics: low three bits pick a base test, bit 3 inverts it (BN/BA pair included)
  function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c, base;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cond[2:0])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = z | (n ^ v);
      3'd3: base = n ^ v;
      3'd4: base = c | z;
      3'd5: base = c;
      3'd6: base = n;
      default: base = v;
    endcase
    return cond[3] ? ~base : base;
  endfunction

  task automatic set_in(input logic le, input logic mod, input logic [3:0] fl,
                        input logic jmpl, input logic b, input logic a,
                        input logic [3:0] cond, input logic call);
    bus.LE = le; bus.EX_modifyCC = mod; bus.EX_flags = fl; bus.EX_jmpl_instr = jmpl;
    bus.ID_B_instr = b; bus.ID_29_a = a; bus.ID_cond = cond; bus.ID_Call_instr = call;
  endtask

  // Check combinational outputs, clock once, then check registered state
  task automatic do_cycle(input string tag);
    logic [3:0] f;
    logic       ct, tk, an;
    logic [1:0] pc;
    #1;
    f  = bus.EX_modifyCC ? bus.EX_flags : m_icc;
    ct = ref_cond(bus.ID_cond, f);
    tk = !m_s && ((bus.ID_B_instr && ct) || bus.ID_Call_instr);
    pc = bus.EX_jmpl_instr ? 2'd2 : (tk ? 2'd1 : 2'd0);
    an = !m_s && !bus.EX_jmpl_instr && bus.ID_B_instr && bus.ID_29_a &&
         (!ct || bus.ID_cond == 4'd8);
    chk({tag, ".taken"}, {3'b0, bus.branch_taken}, {3'b0, tk});
    chk({tag, ".pc_sel"}, {2'b0, bus.pc_sel}, {2'b0, pc});
    chk({tag, ".S_pre"}, {3'b0, bus.S}, {3'b0, m_s});
    @(posedge Clk);
    if (bus.LE) begin
      if (bus.EX_modifyCC) m_icc = bus.EX_flags;
      m_s = an;
    end
    #1;
    chk({tag, ".icc"}, bus.icc, m_icc);
    chk({tag, ".S"}, {3'b0, bus.S}, {3'b0, m_s});
  endtask

  initial begin
    // reset with a BA in ID: outputs must still be quiet
    set_in(1, 0, 4'b0000, 0, 1, 1, 4'b1000, 0);
    #1;
    chk("rst.icc", bus.icc, 4'b0000);
    chk("rst.S", {3'b0, bus.S}, 4'b0);
    chk("rst.pc_sel", {2'b0, bus.pc_sel}, 4'b0);
    chk("rst.taken", {3'b0, bus.branch_taken}, 4'b0);
    #2 R = 1'b0;
    set_in(1, 0, 4'b0000, 0, 0, 0, 4'b0000, 0);
    do_cycle("first");

    // BE taken through bypassed Z
    set_in(1, 1, 4'b0100, 0, 1, 0, 4'b0001, 0);
    do_cycle("be_bypass");
    set_in(1, 1, 4'b0000, 0, 0, 0, 4'b0000, 0);
    do_cycle("clr_icc");

    // BNE a=1 untaken via bypass: annul for exactly one cycle
    set_in(1, 1, 4'b0100, 0, 1, 1, 4'b1001, 0);
    do_cycle("bne_annul");
    set_in(1, 0, 4'b0000, 0, 0, 0, 4'b0000, 0);
    do_cycle("slot");
    do_cycle("after_slot");

    // BA a=1 annuls, BA a=0 does not
    set_in(1, 0, 4'b0000, 0, 1, 1, 4'b1000, 0);
    do_cycle("ba_a1");
    set_in(1, 0, 4'b0000, 0, 0, 0, 4'b0000, 0);
    do_cycle("ba_slot");
    set_in(1, 0, 4'b0000, 0, 1, 0, 4'b1000, 0);
    do_cycle("ba_a0");

    // jmpl in EX overrides the ID branch and suppresses annul
    set_in(1, 0, 4'b0000, 1, 1, 1, 4'b1000, 0);
    do_cycle("jmpl");
    set_in(1, 0, 4'b0000, 1, 1, 1, 4'b0001, 0);
    do_cycle("jmpl_untaken");

    // call never annuls
    set_in(1, 0, 4'b0000, 0, 0, 1, 4'b0000, 1);
    do_cycle("call");

    // stall with an annulling branch: nothing moves
    set_in(1, 1, 4'b0100, 0, 0, 0, 4'b0000, 0);
    do_cycle("set_z");
    set_in(0, 1, 4'b1111, 0, 1, 1, 4'b1001, 0);
    do_cycle("stall1");
    do_cycle("stall2");
    set_in(1, 0, 4'b0000, 0, 1, 1, 4'b1001, 0);
    do_cycle("unstall");
    // reset during the squash cycle clears S at once
    set_in(1, 0, 4'b0000, 0, 1, 1, 4'b1000, 0);
    #1 R = 1'b1;
    #1;
    m_s = 1'b0; m_icc = 4'b0000;
    chk("mid_rst.S", {3'b0, bus.S}, 4'b0);
    chk("mid_rst.icc", bus.icc, 4'b0000);
    chk("mid_rst.pc_sel", {2'b0, bus.pc_sel}, 4'b0);
    #1 R = 1'b0;
    set_in(1, 0, 4'b0000, 0, 0, 0, 4'b0000, 0);
    do_cycle("post_rst");

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      set_in(($urandom_range(0, 7) != 0), 1'($urandom), 4'($urandom),
             ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
             4'($urandom), ($urandom_range(0, 5) == 0));
      do_cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
